// File: rtl/div_pkg.sv
// Shared widths, word types and FSM states
// for the sequential 64/32 divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int DVD_W = 64;

  typedef logic [DIV_W-1:0] word_t;
  typedef logic [DVD_W-1:0] dword_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration:
// shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  word_t rem,
  input  logic  shift_bit,
  input  word_t divisor,
  output word_t new_rem,
  output logic  q_bit
);

  logic [DIV_W:0] t;
  logic [DIV_W:0] d;

  assign t = {rem, shift_bit};
  assign d = {1'b0, divisor};

  // rem < divisor on entry, so t - d fits in DIV_W bits
  assign q_bit   = (t >= d);
  assign new_rem = q_bit ? word_t'(t - d)
                         : t[DIV_W-1:0];

endmodule

// File: rtl/div64x32_seq.sv
// Sequential unsigned 64/32 divider, one quotient bit
// per clock, start/busy handshake, 32-cycle latency.
module div64x32_seq
  import div_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  dword_t dividend,
  input  word_t  divisor,
  output logic   busy,
  output word_t  quotient,
  output word_t  remainder,
  output logic   err
);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;
  word_t      rem;
  word_t      qsh;
  word_t      dvs;
  logic       fail;
  word_t      new_rem;
  logic       q_bit;
  logic       done;
  logic       launch;
  logic       bad;

  div_step u_step (
    .rem       (rem),
    .shift_bit (qsh[DIV_W-1]),
    .divisor   (dvs),
    .new_rem   (new_rem),
    .q_bit     (q_bit)
  );

  assign busy   = (state == RUN);
  assign done   = (state == RUN) && (cnt == 5'd31);
  assign launch = (state == IDLE) && start;
  // Quotient would not fit in 32 bits (also covers /0)
  assign bad    = (divisor == '0) ||
                  (dividend[DVD_W-1:DIV_W] >= divisor);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      qsh       <= '0;
      dvs       <= '0;
      fail      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        rem  <= dividend[DVD_W-1:DIV_W];
        qsh  <= dividend[DIV_W-1:0];
        dvs  <= divisor;
        cnt  <= '0;
        fail <= bad;
      end else if (state == RUN) begin
        rem <= new_rem;
        qsh <= {qsh[DIV_W-2:0], q_bit};
        cnt <= cnt + 5'd1;
        if (done) begin
          if (fail) begin
            quotient  <= '1;
            remainder <= '0;
            err       <= 1'b1;
          end else begin
            quotient  <= {qsh[DIV_W-2:0], q_bit};
            remainder <= new_rem;
            err       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_div64x32_seq.sv
// Directed self-checking bench for div64x32_seq.
// Inputs driven on the falling edge, outputs sampled there too.
module tb_div64x32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        err;

  int errors;
  int checks;
  int cyc;

  div64x32_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  // Launch one op, count busy cycles (bounded)
  task automatic run_op(
    input  logic [63:0] dvd,
    input  logic [31:0] dvs,
    output int          n
  );
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_res(
    input string       tag,
    input int          n,
    input logic [31:0] q,
    input logic [31:0] r,
    input logic        e
  );
    chk({tag, ".cyc"}, 64'(n), 64'd32);
    chk({tag, ".q"}, 64'(quotient), 64'(q));
    chk({tag, ".r"}, 64'(remainder), 64'(r));
    chk({tag, ".err"}, 64'(err), 64'(e));
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.q", 64'(quotient), 64'd0);
    chk("rst.r", 64'(remainder), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    reset = 1'b0;

    // 313552739 * 207231267
    run_op(64'd64977931374290313, 32'd207231267, cyc);
    chk_res("inv", cyc, 32'd313552739, 32'd0, 1'b0);

    run_op(64'd183494042, 32'd6435, cyc);
    chk_res("rem", cyc, 32'd28515, 32'd17, 1'b0);

    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, cyc);
    chk_res("max", cyc, 32'hFFFF_FFFF, 32'd0, 1'b0);

    run_op(64'd12345, 32'd0, cyc);
    chk_res("dz", cyc, 32'hFFFF_FFFF, 32'd0, 1'b1);

    run_op(64'h1_0000_0000, 32'd1, cyc);
    chk_res("ovf", cyc, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Prior result: 100 / 7 = 14 r 2
    run_op(64'd100, 32'd7, cyc);
    chk_res("pre", cyc, 32'd14, 32'd2, 1'b0);

    // Start pulsed mid-RUN must be ignored
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 64'd5;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.busy", 64'(busy), 64'd1);
    chk("mid.hold.q", 64'(quotient), 64'd14);
    chk("mid.hold.r", 64'(remainder), 64'd2);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("mid.q", 64'(quotient), 64'd111);
    chk("mid.r", 64'(remainder), 64'd1);
    chk("mid.err", 64'(err), 64'd0);
    @(negedge clk);
    chk("mid.noq", 64'(busy), 64'd0);

    // Reset around iteration 10
    @(negedge clk);
    dividend = 64'd77777;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rr.busy0", 64'(busy), 64'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rr.busy", 64'(busy), 64'd0);
    chk("rr.q", 64'(quotient), 64'd0);
    chk("rr.r", 64'(remainder), 64'd0);
    chk("rr.err", 64'(err), 64'd0);

    run_op(64'd1000001, 32'd10, cyc);
    chk_res("post", cyc, 32'd100000, 32'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
